// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the mem_initiator slice.
// Provides addr_t, data_t, state_t, MEM_DEPTH and the latency counter width.
package mem_pkg;

  localparam int MEM_DEPTH = 4;
  localparam int LAT_W     = 3;

  typedef logic [1:0] addr_t;
  typedef logic [7:0] data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

endpackage

// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready request/response front end driving a 4x8 memory.
// Ports: req_* in, rsp_* out, addr/wr_en/rd_en/wdata/rdata memory side, busy, counters.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  addr_t            req_addr,
  input  data_t            req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output addr_t            rsp_addr,
  output data_t            rsp_rdata,
  output addr_t            addr,
  output logic             wr_en,
  output logic             rd_en,
  output data_t            wdata,
  input  data_t            rdata,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  state_t             state, state_d;
  logic [LAT_W-1:0]   lat, lat_d;
  logic               req_ready_d;
  logic               rsp_valid_d;
  addr_t              rsp_addr_d;
  data_t              rsp_rdata_d;
  addr_t              addr_d;
  logic               wr_en_d;
  logic               rd_en_d;
  data_t              wdata_d;
  logic               busy_d;
  logic [CNT_W-1:0]   wr_count_d;
  logic [CNT_W-1:0]   rd_count_d;

  always_comb begin
    state_d     = state;
    lat_d       = lat;
    rsp_valid_d = rsp_valid;
    rsp_addr_d  = rsp_addr;
    rsp_rdata_d = rsp_rdata;
    addr_d      = addr;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wdata_d     = wdata;
    wr_count_d  = wr_count;
    rd_count_d  = rd_count;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_write) begin
            wr_en_d    = 1'b1;
            wdata_d    = req_wdata;
            wr_count_d = wr_count + CNT_W'(1);
          end else begin
            rd_en_d    = 1'b1;
            rsp_addr_d = req_addr;
            lat_d      = LAT_W'(RD_LATENCY);
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // lat hits 0 one edge after the last decrement, which lines the
        // capture up with edge RD_LATENCY+1 after the accept.
        if (lat == '0) begin
          rsp_rdata_d = rdata;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          lat_d = lat - LAT_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rd_count_d  = rd_count + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
      addr      <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      wdata     <= '0;
      busy      <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      state     <= state_d;
      lat       <= lat_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_addr  <= rsp_addr_d;
      rsp_rdata <= rsp_rdata_d;
      addr      <= addr_d;
      wr_en     <= wr_en_d;
      rd_en     <= rd_en_d;
      wdata     <= wdata_d;
      busy      <= busy_d;
      wr_count  <= wr_count_d;
      rd_count  <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: directed bench, RD_LATENCY=1 and RD_LATENCY=3 instances.
// Shared request inputs, per-instance memory model with latency pipeline.
module tb_mem_initiator;
  import mem_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  req_valid = 1'b0;
  logic  req_write = 1'b0;
  addr_t req_addr = '0;
  data_t req_wdata = '0;
  logic  rsp_ready = 1'b0;

  logic        rq1, rv1, we1, re1, bz1;
  addr_t       ra1, a1;
  data_t       rd1, wd1, rdata1;
  logic [15:0] wc1, rc1;
  logic        rq3, rv3, we3, re3, bz3;
  addr_t       ra3, a3;
  data_t       rd3, wd3, rdata3;
  logic [15:0] wc3, rc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_initiator #(.RD_LATENCY(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rq1),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_addr(ra1), .rsp_rdata(rd1),
    .addr(a1), .wr_en(we1), .rd_en(re1),
    .wdata(wd1), .rdata(rdata1), .busy(bz1),
    .wr_count(wc1), .rd_count(rc1)
  );

  mem_initiator #(.RD_LATENCY(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(rq3),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_addr(ra3), .rsp_rdata(rd3),
    .addr(a3), .wr_en(we3), .rd_en(re3),
    .wdata(wd3), .rdata(rdata3), .busy(bz3),
    .wr_count(wc3), .rd_count(rc3)
  );

  // Memory models: rdata is valid only in the cycle before the
  // capture edge; otherwise it reads 0.
  data_t mem1 [4];
  data_t mem3 [4];
  logic  p1_v = 1'b0;
  data_t p1_d = '0;
  logic  p3_v [3] = '{1'b0, 1'b0, 1'b0};
  data_t p3_d [3] = '{8'h0, 8'h0, 8'h0};

  always @(posedge clk) begin
    if (we1) mem1[a1] <= wd1;
    p1_v <= re1;
    p1_d <= mem1[a1];
    if (we3) mem3[a3] <= wd3;
    p3_v[0] <= re3;
    p3_d[0] <= mem3[a3];
    p3_v[1] <= p3_v[0];
    p3_d[1] <= p3_d[0];
    p3_v[2] <= p3_v[1];
    p3_d[2] <= p3_d[1];
  end

  assign rdata1 = p1_v ? p1_d : 8'h00;
  assign rdata3 = p3_v[2] ? p3_d[2] : 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input addr_t a, input data_t d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    data_t wv [4];
    wv = '{8'h11, 8'h22, 8'h33, 8'h44};

    // reset state
    step();
    step();
    chk("rst_req_ready", 32'(rq1), 32'd1);
    chk("rst_wr_en", 32'(we1), 32'd0);
    chk("rst_rd_en", 32'(re1), 32'd0);
    chk("rst_rsp_valid", 32'(rv1), 32'd0);
    chk("rst_busy", 32'(bz1), 32'd0);
    chk("rst_wr_count", 32'(wc1), 32'd0);
    rst = 1'b1;
    step();

    // single write
    req(1'b1, 2'd2, 8'hA5);
    step();
    req_valid = 1'b0;
    chk("w1_wr_en", 32'(we1), 32'd1);
    chk("w1_addr", 32'(a1), 32'd2);
    chk("w1_wdata", 32'(wd1), 32'hA5);
    chk("w1_wr_count", 32'(wc1), 32'd1);
    chk("w1_rsp_valid", 32'(rv1), 32'd0);
    step();
    chk("w1_wr_en_off", 32'(we1), 32'd0);
    chk("w1_addr_hold", 32'(a1), 32'd2);

    // back-to-back writes
    for (int i = 0; i < 4; i++) begin
      req(1'b1, addr_t'(i), wv[i]);
      step();
      chk("b2b_wr_en", 32'(we1), 32'd1);
      chk("b2b_addr", 32'(a1), 32'(i));
      chk("b2b_wdata", 32'(wd1), 32'(wv[i]));
      chk("b2b_req_ready", 32'(rq1), 32'd1);
    end
    chk("b2b_wr_count", 32'(wc1), 32'd5);

    // preload 0x5C at 1 and 0xE7 at 3
    req(1'b1, 2'd1, 8'h5C);
    step();
    req(1'b1, 2'd3, 8'hE7);
    step();
    req_valid = 1'b0;
    step();
    chk("pre_wr_count", 32'(wc1), 32'd7);

    // read addr 1, rsp_ready already high
    rsp_ready = 1'b1;
    req(1'b0, 2'd1, 8'h00);
    step();
    req_valid = 1'b0;
    chk("r1_rd_en", 32'(re1), 32'd1);
    chk("r1_addr", 32'(a1), 32'd1);
    chk("r1_wr_en", 32'(we1), 32'd0);
    chk("r1_req_ready", 32'(rq1), 32'd0);
    chk("r1_busy", 32'(bz1), 32'd1);
    step();
    chk("r1_rd_en_off", 32'(re1), 32'd0);
    chk("r1_rsp_early", 32'(rv1), 32'd0);
    step();
    chk("r1_rsp_valid", 32'(rv1), 32'd1);
    chk("r1_rsp_addr", 32'(ra1), 32'd1);
    chk("r1_rsp_rdata", 32'(rd1), 32'h5C);
    step();
    chk("r1_rsp_done", 32'(rv1), 32'd0);
    chk("r1_rd_count", 32'(rc1), 32'd1);
    chk("r1_req_ready", 32'(rq1), 32'd1);
    chk("r1_busy_off", 32'(bz1), 32'd0);
    step();
    step();
    chk("r1_l3_idle", 32'(bz3), 32'd0);

    // stalled response with a pending write
    rsp_ready = 1'b0;
    req(1'b0, 2'd1, 8'h00);
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("st_rsp_valid", 32'(rv1), 32'd1);
    req(1'b1, 2'd0, 8'h99);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_rsp_hold", 32'(rv1), 32'd1);
      chk("st_rdata_hold", 32'(rd1), 32'h5C);
      chk("st_req_ready", 32'(rq1), 32'd0);
      chk("st_wr_en", 32'(we1), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("st_done", 32'(rv1), 32'd0);
    chk("st_rd_count", 32'(rc1), 32'd2);
    chk("st_wr_blocked", 32'(we1), 32'd0);
    step();
    req_valid = 1'b0;
    chk("st_wr_en", 32'(we1), 32'd1);
    chk("st_wr_addr", 32'(a1), 32'd0);
    chk("st_wr_data", 32'(wd1), 32'h99);
    chk("st_wr_count", 32'(wc1), 32'd8);
    step();

    // RD_LATENCY = 3 read of 0xE7
    req(1'b0, 2'd3, 8'h00);
    step();
    req_valid = 1'b0;
    chk("l3_rd_en", 32'(re3), 32'd1);
    step();
    step();
    step();
    chk("l3_rsp_early", 32'(rv3), 32'd0);
    step();
    chk("l3_rsp_valid", 32'(rv3), 32'd1);
    chk("l3_rsp_rdata", 32'(rd3), 32'hE7);
    chk("l3_rsp_addr", 32'(ra3), 32'd3);
    step();
    chk("l3_done", 32'(rv3), 32'd0);
    chk("l3_rd_count", 32'(rc3), 32'd3);
    step();

    // reset during RD_WAIT
    req(1'b0, 2'd2, 8'h00);
    step();
    req_valid = 1'b0;
    step();
    chk("mr_busy_pre", 32'(bz3), 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_req_ready", 32'(rq3), 32'd1);
    chk("mr_busy", 32'(bz3), 32'd0);
    chk("mr_rd_en", 32'(re3), 32'd0);
    chk("mr_rsp_valid", 32'(rv3), 32'd0);
    chk("mr_wr_count", 32'(wc3), 32'd0);
    chk("mr_rd_count", 32'(rc3), 32'd0);
    chk("mr_addr", 32'(a3), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_rsp", 32'(rv3), 32'd0);
    end
    req(1'b1, 2'd1, 8'h3C);
    step();
    req_valid = 1'b0;
    chk("mr_wr_en", 32'(we3), 32'd1);
    chk("mr_wr_data", 32'(wd3), 32'h3C);
    chk("mr_wr_cnt", 32'(wc3), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
